// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and line-level constants for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmitter state encoding (explicit 3-bit width)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO with push/pop, full/empty flags and level.
//               Overflowing pushes and underflowing pops are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == c_LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop  & ~w_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N1 or 8E1. Bytes are queued in a small
//               FIFO and serialised LSB first onto a registered tx line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        cfg_div_i,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    uart_tx_state_e          r_state;
    logic [7:0]              r_shift;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [2:0]              r_idx;
    logic                    r_tx;

    logic                        w_full;
    logic                        w_empty;
    logic [7:0]                  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic                        w_bit_end;
    logic                        w_load;

    // Last cycle of the current bit period
    assign w_bit_end = (r_cnt == '0);

    // Start a new frame from IDLE, or back-to-back straight out of STOP
    assign w_load = ~w_empty &
                    ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (tx_valid_i),
        .i_wr_data (tx_data_i),
        .i_pop     (w_load),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Frame sequencer: state, shift register, bit-period and bit-index counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= UART_IDLE_LVL;
        end else if (w_load) begin
            // Divisor is sampled only here so mid-frame changes wait a frame
            r_shift <= w_head;
            r_div   <= cfg_div_i;
            r_cnt   <= cfg_div_i;
            r_tx    <= UART_START_BIT;
            r_state <= START;
        end else if (r_state != IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end else begin
                r_cnt <= r_div;
                case (r_state)
                    START: begin
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                    DATA: begin
                        if (r_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= even_parity(r_shift);
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= UART_STOP_BIT;
                                r_state <= STOP;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end
                    PARITY: begin
                        r_tx    <= UART_STOP_BIT;
                        r_state <= STOP;
                    end
                    STOP: begin
                        // FIFO empty here, otherwise w_load would have fired
                        r_tx    <= UART_IDLE_LVL;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_tx    <= UART_IDLE_LVL;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_o         = r_tx;
    assign tx_ready_o   = ~w_full;
    assign busy_o       = (r_state != IDLE) | (w_level != '0);
    assign fifo_level_o = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx (8N1 and 8E1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_div;
    logic [7:0]  tx_data;
    logic        valid0, valid1;
    logic        ready0, ready1;
    logic        tx0, tx1;
    logic        busy0, busy1;
    logic [2:0]  level0, level1;

    int n_asserts = 0;
    int n_fail    = 0;

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .DIV_WIDTH(16)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .cfg_div_i    (cfg_div),
        .tx_data_i    (tx_data),
        .tx_valid_i   (valid0),
        .tx_ready_o   (ready0),
        .tx_o         (tx0),
        .busy_o       (busy0),
        .fifo_level_o (level0)
    );

    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1), .DIV_WIDTH(16)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .cfg_div_i    (cfg_div),
        .tx_data_i    (tx_data),
        .tx_valid_i   (valid1),
        .tx_ready_o   (ready1),
        .tx_o         (tx1),
        .busy_o       (busy1),
        .fifo_level_o (level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the first start-bit edge; checks every
    // cycle of the frame and decodes it mid-bit like a line monitor.
    task automatic frame(input int sel, input logic [7:0] d, input int div,
                         input bit par, input bit exp_par);
        logic [10:0] bits;
        logic [7:0]  rx;
        logic        rxp;
        logic        t;
        int          nb;
        nb   = par ? 11 : 10;
        bits = par ? {1'b1, exp_par, d, 1'b0} : {2'b11, d, 1'b0};
        rx   = '0;
        rxp  = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= div; c++) begin
                t = (sel != 0) ? tx1 : tx0;
                check($sformatf("frame_%0h_bit%0d_cyc%0d", d, b, c), {31'd0, t}, {31'd0, bits[b]});
                if (c == div / 2) begin
                    if (b >= 1 && b <= 8) rx[b-1] = t;
                    if (par && b == 9) rxp = t;
                end
                @(negedge clk);
            end
        end
        check($sformatf("decode_%0h", d), {24'd0, rx}, {24'd0, d});
        if (par) check($sformatf("parity_xor_%0h", d), {31'd0, ^{rx, rxp}}, 32'd0);
    endtask

    // Safety net so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q [6];
        int         n;
        int         waited;
        logic       rd;
        logic       saw_low;
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b1; cfg_div = 16'd3; tx_data = 8'h00; valid0 = 1'b0; valid1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx0",    {31'd0, tx0},    32'd1);
        check("rst_ready0", {31'd0, ready0}, 32'd1);
        check("rst_busy0",  {31'd0, busy0},  32'd0);
        check("rst_level0", {29'd0, level0}, 32'd0);
        check("rst_tx1",    {31'd0, tx1},    32'd1);
        check("rst_level1", {29'd0, level1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x55, div 3
        cfg_div = 16'd3; tx_data = 8'h55; valid0 = 1'b1;
        @(negedge clk);                 // after edge k
        valid0 = 1'b0;
        check("t1_tx_idle_at_k", {31'd0, tx0},    32'd1);
        check("t1_level_at_k",   {29'd0, level0}, 32'd1);
        check("t1_busy_at_k",    {31'd0, busy0},  32'd1);
        @(negedge clk);                 // after edge k+1
        check("t1_level_popped", {29'd0, level0}, 32'd0);
        frame(0, 8'h55, 3, 1'b0, 1'b0);
        check("t1_busy_k41", {31'd0, busy0}, 32'd0);
        check("t1_tx_k41",   {31'd0, tx1},   32'd1);

        // Parity build: 0x07 -> parity 1, 0x03 -> parity 0
        cfg_div = 16'd1; tx_data = 8'h07; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        frame(1, 8'h07, 1, 1'b1, 1'b1);
        check("t2_busy_after_07", {31'd0, busy1}, 32'd0);
        tx_data = 8'h03; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        frame(1, 8'h03, 1, 1'b1, 1'b0);
        check("t2_busy_after_03", {31'd0, busy1}, 32'd0);

        // Back-to-back frames, div 9
        cfg_div = 16'd9; tx_data = 8'hA5; valid0 = 1'b1;
        @(negedge clk);                 // after edge k
        tx_data = 8'h0F;
        @(negedge clk);                 // after edge k+1: pop and push together
        valid0 = 1'b0;
        check("t3_level_pushpop", {29'd0, level0}, 32'd1);
        frame(0, 8'hA5, 9, 1'b0, 1'b0);
        frame(0, 8'h0F, 9, 1'b0, 1'b0);
        check("t3_busy_end", {31'd0, busy0}, 32'd0);

        // FIFO fill and back-pressure, div 99
        cfg_div = 16'd99; n = 0; tx_data = q[0]; valid0 = 1'b1;
        for (int i = 0; i < 8 && n < 5; i++) begin
            rd = ready0;
            @(negedge clk);
            if (rd) begin
                n++;
                tx_data = q[n];
            end
        end
        check("t4_accepted",  n,                  32'd5);
        check("t4_level_full", {29'd0, level0},   32'd4);
        check("t4_ready_low",  {31'd0, ready0},   32'd0);
        waited = 0;
        while (!ready0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("t4_stall_cycles", waited,           32'd997);
        check("t4_level_drain",  {29'd0, level0},  32'd3);
        check("t4_next_start",   {31'd0, tx0},     32'd0);
        @(negedge clk);
        valid0 = 1'b0;
        check("t4_level_refill", {29'd0, level0},  32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_level", {29'd0, level0}, 32'd0);
        check("t4_rst_tx",    {31'd0, tx0},    32'd1);

        // Reset during DATA bit 3 with two bytes queued, div 3
        cfg_div = 16'd3; tx_data = 8'hA1; valid0 = 1'b1;
        @(negedge clk);                 // after k
        tx_data = 8'hB2;
        @(negedge clk);                 // after k+1
        tx_data = 8'hC3;
        @(negedge clk);                 // after k+2
        valid0 = 1'b0;
        repeat (16) @(negedge clk);     // after k+18, inside bit 3
        check("t5_bit3_value", {31'd0, tx0},    32'd0);
        check("t5_queued",     {29'd0, level0}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx_high",  {31'd0, tx0},    32'd1);
        check("t5_level0",   {29'd0, level0}, 32'd0);
        check("t5_busy0",    {31'd0, busy0},  32'd0);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx0 !== 1'b1) saw_low = 1'b1;
            @(negedge clk);
        end
        check("t5_no_start_after_rst", {31'd0, saw_low}, 32'd0);

        // Divisor change mid-frame applies to the next frame only
        cfg_div = 16'd3; tx_data = 8'h3C; valid0 = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        @(negedge clk);
        valid0 = 1'b0;
        cfg_div = 16'd7;
        frame(0, 8'h3C, 3, 1'b0, 1'b0);
        frame(0, 8'hC3, 7, 1'b0, 1'b0);
        check("t6_busy_end", {31'd0, busy0}, 32'd0);

        // Divisor 0: one cycle per bit
        cfg_div = 16'd0; tx_data = 8'h81; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        @(negedge clk);
        frame(0, 8'h81, 0, 1'b0, 1'b0);
        check("t7_busy_end", {31'd0, busy0}, 32'd0);
        check("t7_tx_idle",  {31'd0, tx0},   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Synthesizable UART transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises each one onto tx_o.
- Frame is 8N1, or 8E1 when parity is enabled: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit.
- Sits in the peripheral subsystem and drives the chip-level UART TX pad.
- Framing is bit-compatible with the bench's UART line monitor, which checks parity as XOR(data, parity) == 0.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO; power of two, minimum 2.
- PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and the stop bit.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cfg_div_i  input  DIV_WIDTH  bit period minus one, in clk cycles
- tx_data_i  input  8  byte to transmit
- tx_valid_i  input  1  tx_data_i is valid
- tx_ready_o  output  1  FIFO can accept a byte this cycle
- tx_o  output  1  serial line, idle high, registered
- busy_o  output  1  frame in progress or FIFO non-empty
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset:
  - Single clock domain: clk. Reset rst is synchronous and active-high.
  - While rst=1: tx_o=1, tx_ready_o=1, busy_o=0, fifo_level_o=0, FSM in IDLE, counters cleared, FIFO emptied.
- Handshake:
  - A byte is pushed on any edge where tx_valid_i & tx_ready_o.
  - tx_ready_o = !full; it does not depend on a same-cycle pop, so there is no combinational path from the FSM to ready.
  - Push and pop in the same cycle: level unchanged, both operations take effect.
- Bit timing:
  - A bit lasts cfg_div_i+1 cycles.
  - cfg_div_i is latched at frame start; changes mid-frame apply to the next frame.
  - cfg_div_i=0 is legal (1 cycle per bit).
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the shift register, latch the divisor, set tx_o<=0 and go to START. A byte accepted into an empty FIFO at edge k drives tx_o low from edge k+1.
  - START: after one bit period, go to DATA with bit index 0 and tx_o<=data[0].
  - DATA: after each bit period, advance the index. After bit 7 go to PARITY (PARITY_EN=1, tx_o<=^data) or STOP (tx_o<=1).
  - PARITY: after one bit period, go to STOP with tx_o<=1.
  - STOP: after one bit period, if the FIFO is non-empty, pop and go directly to START with tx_o<=0 (no idle gap); otherwise go to IDLE.
- Counters:
  - Bit-period counter counts down from the latched divisor to 0; a state advance occurs on the 0 cycle.
  - Bit index is 3 bits and never wraps past 7.
- Frame length: 10 bit periods, or 11 with parity.
- busy_o = (state != IDLE) | (level != 0). It is combinational from registers.
- FIFO pointers wrap modulo FIFO_DEPTH. Level saturates logically at FIFO_DEPTH, because ready is low when full.
- Reset mid-frame: line returns high on the edge after rst is sampled. The partial frame and all buffered bytes are discarded.

Decomposition:
- Package uart_pkg:
  - typedef enum uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparams UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_IDLE_LVL=1'b1
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised by depth and width 8. It is reusable by a future RX path.
- uart_tx itself holds the FSM, shift register and counters.

Test Plan:
- cfg_div_i=3, push 0x55 at edge k -> tx_o low from k+1, then 1,0,1,0,1,0,1,0, then 1, each for 4 cycles; busy_o falls at k+41.
- PARITY_EN=1, cfg_div_i=1, push 0x07 -> parity bit is 1; frame is 22 cycles; bench monitor reports no parity error. Push 0x03 -> parity bit is 0.
- cfg_div_i=9, push 0xA5 and 0x0F on consecutive cycles -> two frames, 200 cycles total, stop bit of the first immediately followed by the start bit of the second; monitor decodes A5, 0F.
- FIFO_DEPTH=4, cfg_div_i=99, hold tx_valid_i for 6 bytes -> first byte enters the shifter, the next 4 fill the FIFO, tx_ready_o low with fifo_level_o=4, and the 6th byte stalls until the first frame's stop bit ends.
- Assert rst for 1 cycle during DATA bit 3 with 2 bytes queued -> tx_o=1 on the next edge, fifo_level_o=0, busy_o=0, and no further start bit.
- Change cfg_div_i from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
